// File: rtl/morph3x3_bin_pkg.sv
// rtl/morph3x3_bin_pkg.sv - shared encodings and helpers for the 3x3 binary morphology stage
package morph_pkg;

   // Run-time operator select; 2'b11 behaves as bypass
   typedef enum logic [1:0] {
      MODE_BYPASS  = 2'b00,
      MODE_ERODE   = 2'b01,
      MODE_DILATE  = 2'b10,
      MODE_BYPASS2 = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

   // Per-bit defaults for the foreground/background output codes
   localparam logic DEF_PIX_FG_BIT = 1'b0;
   localparam logic DEF_PIX_BG_BIT = 1'b1;

   // Normalise an input bit so that foreground reads as 1
   function automatic logic norm_fg(input logic p, input logic fg_val);
      return p ~^ fg_val;
   endfunction

endpackage

// File: rtl/bin_line_buf2.sv
// rtl/bin_line_buf2.sv - two chained one-line delays for a 1-bit pixel stream
module bin_line_buf2 #(
   parameter int IMG_W = 640
) (
   input  logic clk,
   input  logic i_en,
   input  logic i_bin,
   output logic o_row1,
   output logic o_row2
);

   logic [IMG_W-1:0] r_line1;
   logic [IMG_W-1:0] r_line2;

   // Tails hold the pixels written exactly one and two lines ago
   assign o_row1 = r_line1[IMG_W-1];
   assign o_row2 = r_line2[IMG_W-1];

   // Shift both delays once per accepted pixel; contents need no reset
   always_ff @(posedge clk) begin
      if (i_en) begin
         r_line1 <= {r_line1[IMG_W-2:0], i_bin};
         r_line2 <= {r_line2[IMG_W-2:0], r_line1[IMG_W-1]};
      end
   end

endmodule

// File: rtl/morph3x3_bin.sv
// rtl/morph3x3_bin.sv - 3x3 binary erode/dilate/bypass stage with frame FSM and 3-stage pipeline
module morph3x3_bin
   import morph_pkg::*;
#(
   parameter int                IMG_W  = 640,
   parameter int                IMG_H  = 480,
   parameter int                DATA_W = 16,
   parameter logic              FG_VAL = 1'b0,
   parameter logic [DATA_W-1:0] PIX_FG = {DATA_W{DEF_PIX_FG_BIT}},
   parameter logic [DATA_W-1:0] PIX_BG = {DATA_W{DEF_PIX_BG_BIT}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode_i,
   input  logic              frame_start_i,
   input  logic              pix_valid_i,
   input  logic              pix_bin_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_bin_o,
   output logic              frame_done_o
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   state_e          r_state, w_state_nxt;
   mode_e           r_mode;
   logic [CW-1:0]   r_col;
   logic [RW-1:0]   r_row;

   logic [CW-1:0]   w_col;
   logic [RW-1:0]   w_row;
   logic            w_accept;
   logic            w_last;
   mode_e           w_mode;
   logic            w_lb1, w_lb2;

   // S1: window (bit0 = column c, bit2 = column c-2) and position flags
   logic [2:0]      r_win_t, r_win_m, r_win_b;
   logic            r_s1_valid, r_s1_bg, r_s1_top_out, r_s1_left_out, r_s1_last;
   mode_e           r_s1_mode;

   // S2: per-row reductions
   logic [2:0]      w_cmask, w_t, w_m, w_b;
   logic [2:0]      r_s2_and, r_s2_or;
   logic            r_s2_valid, r_s2_ctr, r_s2_bg, r_s2_last;
   mode_e           r_s2_mode;

   // S3: result
   logic            w_fg;
   logic            r_out_valid, r_out_bin, r_out_done;
   logic [DATA_W-1:0] r_out_data;

   // A frame start overrides the counters for a coincident pixel, which becomes (0,0)
   assign w_col    = frame_start_i ? '0 : r_col;
   assign w_row    = frame_start_i ? '0 : r_row;
   assign w_accept = pix_valid_i && (frame_start_i || (r_state == ST_ACTIVE));
   assign w_last   = (w_col == COL_LAST) && (w_row == ROW_LAST);
   assign w_mode   = frame_start_i ? mode_e'(mode_i) : r_mode;

   // Frame state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state: a frame start (re)arms, the last accepted pixel finishes the frame
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (frame_start_i) w_state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            w_state_nxt = ST_ACTIVE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_accept && w_last) w_state_nxt = ST_DONE;
   end

   // Raster counters and shadow mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col  <= '0;
         r_row  <= '0;
         r_mode <= MODE_BYPASS;
      end else begin
         if (frame_start_i) r_mode <= mode_e'(mode_i);
         if (w_accept) begin
            if (w_col == COL_LAST) begin
               r_col <= '0;
               r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
               r_col <= w_col + 1'b1;
               r_row <= w_row;
            end
         end else if (frame_start_i) begin
            r_col <= '0;
            r_row <= '0;
         end
      end
   end

   bin_line_buf2 #(.IMG_W(IMG_W)) u_line_buf (
      .clk    (clk),
      .i_en   (w_accept),
      .i_bin  (pix_bin_i),
      .o_row1 (w_lb1),
      .o_row2 (w_lb2)
   );

   // S1: shift a new normalised column into the window and note border position
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win_t       <= '0;
         r_win_m       <= '0;
         r_win_b       <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_bg       <= 1'b0;
         r_s1_top_out  <= 1'b0;
         r_s1_left_out <= 1'b0;
         r_s1_last     <= 1'b0;
         r_s1_mode     <= MODE_BYPASS;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_win_b       <= {r_win_b[1:0], norm_fg(pix_bin_i, FG_VAL)};
            r_win_m       <= {r_win_m[1:0], norm_fg(w_lb1, FG_VAL)};
            r_win_t       <= {r_win_t[1:0], norm_fg(w_lb2, FG_VAL)};
            r_s1_bg       <= (w_row == '0) || (w_col == '0);
            r_s1_top_out  <= (w_row == RW'(1));
            r_s1_left_out <= (w_col == CW'(1));
            r_s1_last     <= w_last;
            r_s1_mode     <= w_mode;
         end
      end
   end

   // Neighbours above row 0 or left of column 0 are forced to background
   assign w_cmask = r_s1_left_out ? 3'b011 : 3'b111;
   assign w_t     = r_s1_top_out ? 3'b000 : (r_win_t & w_cmask);
   assign w_m     = r_win_m & w_cmask;
   assign w_b     = r_win_b & w_cmask;

   // S2: reduce each window row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_and   <= '0;
         r_s2_or    <= '0;
         r_s2_ctr   <= 1'b0;
         r_s2_bg    <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_mode  <= MODE_BYPASS;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_and  <= {&w_t, &w_m, &w_b};
            r_s2_or   <= {|w_t, |w_m, |w_b};
            r_s2_ctr  <= r_win_m[1];
            r_s2_bg   <= r_s1_bg;
            r_s2_last <= r_s1_last;
            r_s2_mode <= r_s1_mode;
         end
      end
   end

   // Combine row reductions according to the frame's mode
   always_comb begin
      w_fg = 1'b0;
      case (r_s2_mode)
         MODE_ERODE:  w_fg = &r_s2_and;
         MODE_DILATE: w_fg = |r_s2_or;
         default:     w_fg = r_s2_ctr;
      endcase
      if (r_s2_bg) w_fg = 1'b0;
   end

   // S3: output register; idle cycles carry no pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_bin   <= 1'b0;
         r_out_done  <= 1'b0;
      end else begin
         r_out_valid <= r_s2_valid;
         r_out_done  <= r_s2_valid && r_s2_last;
         if (r_s2_valid) begin
            r_out_data <= w_fg ? PIX_FG : PIX_BG;
            r_out_bin  <= w_fg ? FG_VAL : ~FG_VAL;
         end
      end
   end

   assign out_valid_o  = r_out_valid;
   assign out_data_o   = r_out_data;
   assign out_bin_o    = r_out_bin;
   assign frame_done_o = r_out_done;

endmodule
